// File: rtl/ft_pkg.sv
// Shared types and constants for the FTDI TX arbiter.
// Optional framing is controlled by the FT_ARB_HEADER_EN macro.
package ft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LEN  = 2'd2,
    ST_DATA = 2'd3
  } ft_state_t;

  localparam logic [3:0] FT_HDR_MAGIC = 4'hA;
  localparam int         FT_MAX_CH    = 8;
  localparam int         FT_IW        = $clog2(FT_MAX_CH);

endpackage

// File: rtl/ft_tx_arbiter_rr.sv
// Round-robin pick: scans upward from ptr+1 with wrap.
// Purely combinational; returns one-hot grant and its index.
module rr_arbiter
  import ft_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [FT_IW-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [FT_IW-1:0]  idx,
  output logic              any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      k = (int'(ptr) + i) % NUM_CH;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = FT_IW'(k);
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Burst arbiter sharing the SyncFIFO TX stream between NUM_CH sources.
// Define FT_ARB_HEADER_EN to frame each burst with header and length bytes.
module ft_tx_arbiter
  import ft_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     i_req,
  input  logic [NUM_CH*8-1:0]   i_len,
  input  logic [NUM_CH*8-1:0]   i_data,
  input  logic [NUM_CH-1:0]     i_valid,
  output logic [NUM_CH-1:0]     o_ready,
  output logic [NUM_CH-1:0]     o_grant,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  ft_state_t           state;
  logic [FT_IW-1:0]    g;
  logic [FT_IW-1:0]    ptr;
  logic [NUM_CH-1:0]   grant;
  logic [7:0]          cnt;
`ifdef FT_ARB_HEADER_EN
  logic [7:0]          len;
`endif

  logic [NUM_CH-1:0]   pick;
  logic [FT_IW-1:0]    pick_idx;
  logic                pick_any;
  logic [7:0]          req_len;
  logic [7:0]          burst_len;
  logic                src_valid;
  logic [7:0]          src_data;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_rr (
    .req(i_req),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    req_len = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick[c]) req_len = i_len[8*c +: 8];
    end
    burst_len = (req_len > 8'(BURST_MAX)) ?
                8'(BURST_MAX) : req_len;
  end

  // grant is one-hot, so OR-ing the masked lanes selects the source
  always_comb begin
    src_valid = |(grant & i_valid);
    src_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) src_data = src_data | i_data[8*c +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      g     <= '0;
      ptr   <= FT_IW'(NUM_CH-1);
      grant <= '0;
      cnt   <= '0;
`ifdef FT_ARB_HEADER_EN
      len   <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            if (req_len == 8'd0) begin
              ptr <= pick_idx;
            end else begin
              g     <= pick_idx;
              grant <= pick;
              cnt   <= burst_len;
`ifdef FT_ARB_HEADER_EN
              len   <= burst_len;
              state <= ST_HDR;
`else
              state <= ST_DATA;
`endif
            end
          end
        end
`ifdef FT_ARB_HEADER_EN
        ST_HDR: begin
          if (i_ready) state <= ST_LEN;
        end
        ST_LEN: begin
          if (i_ready) state <= ST_DATA;
        end
`endif
        ST_DATA: begin
          if (src_valid && i_ready) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              ptr   <= g;
              grant <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_ready = '0;
    unique case (state)
`ifdef FT_ARB_HEADER_EN
      ST_HDR: begin
        o_valid = 1'b1;
        o_data  = {FT_HDR_MAGIC, 1'b0, g};
      end
      ST_LEN: begin
        o_valid = 1'b1;
        o_data  = len;
      end
`endif
      ST_DATA: begin
        o_valid = src_valid;
        o_data  = src_data;
        o_ready = grant & {NUM_CH{i_ready}};
      end
      default: ;
    endcase
  end

  assign o_grant = grant;
  assign o_busy  = (state != ST_IDLE);

endmodule
